alu_apb_regfile: RTL and testbench
==================================

# alu_apb_regfile

Parametrised APB4 slave register file that holds the ALU's operand, opcode and control registers and returns its status registers. It replaces the fixed four-register ALU register block. New over that block: configurable register count, base address and wait states; byte strobes; pslverr on bad accesses; read-only hardware-fed registers; per-register write-commit pulses.

## Interface
- DATA_W, 32, data width; multiple of 8
- ADDR_W, 32, APB address width
- NUM_REGS, 4, number of 32-bit-aligned registers, 1..16
- BASE_ADDR, 32'h0000_0010, byte address of register 0; register i at BASE_ADDR + 4*i
- WAIT_STATES, 0, extra access-phase cycles before pready, 0..15
- RO_MASK, 0, bit i set: register i is read-only and reads ro_data_i slice i

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- psel  in  1  APB select
- penable  in  1  APB enable (access phase)
- paddr  in  ADDR_W  byte address
- pwrite  in  1  1 = write, 0 = read
- pwdata  in  DATA_W  write data
- pstrb  in  DATA_W/8  write byte strobes
- prdata  out  DATA_W  read data, valid only while pready = 1
- pready  out  1  transfer complete
- pslverr  out  1  transfer error, valid only while pready = 1
- regs_o  out  NUM_REGS*DATA_W  register contents; register i at bits [i*DATA_W +: DATA_W]
- ro_data_i  in  NUM_REGS*DATA_W  hardware values for RO registers; slices of RW registers ignored
- wr_pulse_o  out  NUM_REGS  one-cycle pulse per committed register write

## Operation
- Reset (asynchronous, immediate): state IDLE, pready = 0, pslverr = 0, prdata = 0, wr_pulse_o = 0, all RW registers = 0, wait counter = 0.
- The setup cycle is the only point where paddr and pwrite are sampled; both are latched as index, error flag and direction.
- Decode error: paddr < BASE_ADDR, paddr >= BASE_ADDR + 4*NUM_REGS, or paddr[1:0] != 0.
- RO error: pwrite = 1 to an index with its RO_MASK bit set. Reads of RO registers are legal.
- FSM states:
  - IDLE: when psel & !penable (setup), latch the access. If WAIT_STATES = 0, set pready <= 1 and go to RESP. Otherwise set counter <= 1 and go to WAIT.
  - WAIT: while psel & penable, increment the counter. When counter = WAIT_STATES, set pready <= 1 and go to RESP. If psel = 0, go to IDLE with no effect.
  - RESP: pready = 1 for exactly this cycle; the write commits at the end of it. Next state is IDLE with pready <= 0. If psel = 0 in RESP, abort the write.
- prdata and pslverr are registered and loaded on the same edge that sets pready. They return to 0 on the edge that clears it.
- Read data: register i value (RO: ro_data_i slice sampled at load). On error, prdata = 0 and pslverr = 1.
- Write: for each byte b with pstrb[b] = 1, update reg[idx] byte b from pwdata. Erroring writes change nothing. pstrb = 0 changes nothing and produces no pulse, with pslverr = 0.
- wr_pulse_o[idx] is high for the single cycle after the commit edge, aligned with the updated regs_o.

## Timing
- Access phase lasts WAIT_STATES + 1 cycles. The total transfer, setup included, is WAIT_STATES + 2 cycles.
- Back-to-back transfers: a setup cycle immediately after the RESP cycle is accepted (IDLE samples it).
- penable = 1 without a preceding setup cycle in IDLE is ignored.
- A setup while in WAIT or RESP is a protocol violation. It is not required to be handled.
- Reset asserted mid-transfer: all outputs drop to their reset values asynchronously and no write commits.
- Read-after-write to the same register in the next transfer returns the new value.

## Test plan
- Reset, then read all NUM_REGS = 4 registers -> each returns 0 with pready in the second cycle and pslverr = 0.
- Write 32'hDEAD_BEEF to 0x14 with pstrb = 4'b1111, then read it back -> 32'hDEAD_BEEF. wr_pulse_o[1] is high for one cycle; regs_o[63:32] updates.
- Write 32'h1122_3344 to 0x10 pre-loaded with 32'hAAAA_AAAA, pstrb = 4'b0101 -> reg0 = 32'hAA22_AA44.
- Access to 0x20, 0x0C and 0x11 -> pslverr = 1 with pready, prdata = 0, no register changes. With RO_MASK = 4'b1000, a write to 0x1C -> pslverr = 1, and a read returns ro_data_i[127:96].
- WAIT_STATES = 3: a read shows pready = 0 for 3 access cycles and 1 in the 4th. Dropping psel in the 2nd access cycle of a write -> no commit and no pulse.
- Assert reset_n = 0 during a WAIT-state write -> pready falls at once, registers are 0, and the next transfer after reset completes normally.

Source files
------------

// File: rtl/alu_apb_regfile.sv
// APB4 slave register file for the ALU: RW operand/opcode/control registers,
// read-only hardware-fed status registers, byte strobes, wait states and pslverr.
module alu_apb_regfile #(
  parameter int unsigned         DATA_W      = 32,
  parameter int unsigned         ADDR_W      = 32,
  parameter int unsigned         NUM_REGS    = 4,
  parameter logic [ADDR_W-1:0]   BASE_ADDR   = 32'h0000_0010,
  parameter int unsigned         WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         psel,
  input  logic                         penable,
  input  logic [ADDR_W-1:0]            paddr,
  input  logic                         pwrite,
  input  logic [DATA_W-1:0]            pwdata,
  input  logic [DATA_W/8-1:0]          pstrb,
  output logic [DATA_W-1:0]            prdata,
  output logic                         pready,
  output logic                         pslverr,
  output logic [NUM_REGS*DATA_W-1:0]   regs_o,
  input  logic [NUM_REGS*DATA_W-1:0]   ro_data_i,
  output logic [NUM_REGS-1:0]          wr_pulse_o
);

  localparam int unsigned       STRB_W = DATA_W / 8;
  localparam int unsigned       IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W-1:0] SPAN   = ADDR_W'(4 * NUM_REGS);
  localparam logic [3:0]        WS     = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                            state_q, state_d;
  logic [3:0]                        cnt_q, cnt_d;
  logic [IDX_W-1:0]                  idx_q, idx_d;
  logic                              err_q, err_d;
  logic                              wr_q, wr_d;
  logic                              pready_q, pready_d;
  logic                              pslverr_q, pslverr_d;
  logic [DATA_W-1:0]                 prdata_q, prdata_d;
  logic [NUM_REGS-1:0][DATA_W-1:0]   regs_q, regs_d;
  logic [NUM_REGS-1:0]               pulse_q, pulse_d;

  logic [ADDR_W-1:0] offs_s;
  logic [IDX_W-1:0]  dec_idx_s;
  logic              dec_err_s;
  logic              acc_err_s;
  logic [IDX_W-1:0]  ld_idx_s;
  logic              ld_err_s;
  logic              ld_wr_s;
  logic              ld_s;
  logic [DATA_W-1:0] rd_val_s;

  // Address decode of the setup-phase address.
  always_comb begin
    offs_s    = paddr - BASE_ADDR;
    dec_idx_s = offs_s[IDX_W+1:2];
    dec_err_s = (paddr < BASE_ADDR) || (offs_s >= SPAN) || (paddr[1:0] != 2'b00);
    if (dec_err_s) begin
      acc_err_s = 1'b1;
    end else begin
      acc_err_s = pwrite && RO_MASK[dec_idx_s];
    end
  end

  // Response data is loaded either straight from setup (no wait states) or from the latched access.
  always_comb begin
    if (state_q == S_IDLE) begin
      ld_idx_s = dec_idx_s;
      ld_err_s = acc_err_s;
      ld_wr_s  = pwrite;
    end else begin
      ld_idx_s = idx_q;
      ld_err_s = err_q;
      ld_wr_s  = wr_q;
    end
    rd_val_s = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ld_idx_s == IDX_W'(i)) begin
        rd_val_s = RO_MASK[i] ? ro_data_i[i*DATA_W +: DATA_W] : regs_q[i];
      end else begin
        rd_val_s = rd_val_s;
      end
    end
  end

  // Transfer FSM, response load and write commit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    err_d     = err_q;
    wr_d      = wr_q;
    regs_d    = regs_q;
    pulse_d   = '0;
    ld_s      = 1'b0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (psel && !penable) begin
          idx_d = dec_idx_s;
          err_d = acc_err_s;
          wr_d  = pwrite;
          if (WS == 4'd0) begin
            ld_s    = 1'b1;
            state_d = S_RESP;
          end else begin
            cnt_d   = 4'd1;
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!psel) begin
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end else if (penable) begin
          if (cnt_q == WS) begin
            cnt_d   = 4'd0;
            ld_s    = 1'b1;
            state_d = S_RESP;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        // Dropping psel during the response cycle abandons the write.
        if (psel && wr_q && !err_q) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (idx_q == IDX_W'(i)) begin
              for (int b = 0; b < STRB_W; b++) begin
                if (pstrb[b]) begin
                  regs_d[i][b*8 +: 8] = pwdata[b*8 +: 8];
                end else begin
                  regs_d[i][b*8 +: 8] = regs_q[i][b*8 +: 8];
                end
              end
              pulse_d[i] = |pstrb;
            end else begin
              pulse_d[i] = 1'b0;
            end
          end
        end else begin
          pulse_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (ld_s) begin
      pready_d  = 1'b1;
      pslverr_d = ld_err_s;
      prdata_d  = (ld_err_s || ld_wr_s) ? '0 : rd_val_s;
    end else begin
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      prdata_d  = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      wr_q      <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      regs_q    <= '0;
      pulse_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      wr_q      <= wr_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      regs_q    <= regs_d;
      pulse_q   <= pulse_d;
    end
  end

  assign pready     = pready_q;
  assign pslverr    = pslverr_q;
  assign prdata     = prdata_q;
  assign regs_o     = regs_q;
  assign wr_pulse_o = pulse_q;

endmodule

// File: tb/tb_alu_apb_regfile.sv
// Bench for alu_apb_regfile: one zero-wait RW instance and one 3-wait-state
// instance with register 3 read-only, both checked against an array model.
module tb_alu_apb_regfile;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         psel_v [2];
  logic         penable;
  logic [31:0]  paddr;
  logic         pwrite;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic [127:0] ro_data;
  logic [31:0]  prdata_v [2];
  logic         pready_v [2];
  logic         pslverr_v [2];
  logic [127:0] regs_v [2];
  logic [3:0]   pulse_v [2];

  logic [31:0]  mem [2][4];
  logic [3:0]   rom [2];
  int           ws [2];
  int           n_chk = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;

  alu_apb_regfile #(.WAIT_STATES(0), .RO_MASK(4'b0000)) u0 (
    .clk(clk), .reset_n(reset_n), .psel(psel_v[0]), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_v[0]),
    .pready(pready_v[0]), .pslverr(pslverr_v[0]), .regs_o(regs_v[0]),
    .ro_data_i(ro_data), .wr_pulse_o(pulse_v[0]));

  alu_apb_regfile #(.WAIT_STATES(3), .RO_MASK(4'b1000)) u1 (
    .clk(clk), .reset_n(reset_n), .psel(psel_v[1]), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_v[1]),
    .pready(pready_v[1]), .pslverr(pslverr_v[1]), .regs_o(regs_v[1]),
    .ro_data_i(ro_data), .wr_pulse_o(pulse_v[1]));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_err(input int d, input logic [31:0] a, input logic w);
    if (a < 32'h10 || a >= 32'h20 || (a % 4) != 0) return 1'b1;
    return w && rom[d][(a - 32'h10) / 4];
  endfunction

  function automatic logic [127:0] m_regs(input int d);
    return {mem[d][3], mem[d][2], mem[d][1], mem[d][0]};
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) mem[d][i] = 32'h0;
  endtask

  task automatic idle();
    @(negedge clk);
    psel_v[0] = 1'b0;
    psel_v[1] = 1'b0;
    penable   = 1'b0;
  endtask

  task automatic xfer(input int d, input logic [31:0] a, input logic w, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    psel_v[d] = 1'b1; psel_v[1-d] = 1'b0; penable = 1'b0;
    paddr = a; pwrite = w; pwdata = wd; pstrb = st;
    @(negedge clk);
    penable = 1'b1;
    lat = 1;
    while (pready_v[d] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd = prdata_v[d];
    er = pslverr_v[d];
  endtask

  task automatic run(input int d, input logic [31:0] a, input logic w, input logic [31:0] wd,
                     input logic [3:0] st, input bit post_idle);
    logic [31:0] rd, e_rd, nv;
    logic        er, e_err;
    logic [3:0]  e_pulse;
    int          lat, idx;
    e_err   = m_err(d, a, w);
    idx     = e_err ? 0 : int'((a - 32'h10) / 4);
    e_rd    = 32'h0;
    e_pulse = 4'h0;
    if (!e_err && !w) e_rd = rom[d][idx] ? ro_data[idx*32 +: 32] : mem[d][idx];
    if (!e_err && w && st != 4'h0) begin
      nv = mem[d][idx];
      for (int b = 0; b < 4; b++) if (st[b]) nv[b*8 +: 8] = wd[b*8 +: 8];
      mem[d][idx] = nv;
      e_pulse = 4'h1 << idx;
    end
    xfer(d, a, w, wd, st, rd, er, lat);
    chk("latency", lat, ws[d] + 1);
    chk("pslverr", er, e_err);
    if (!w || e_err) chk("prdata", rd, e_rd);
    if (post_idle) begin
      idle();
      chk("wr_pulse", pulse_v[d], e_pulse);
      chk("regs_o", regs_v[d], m_regs(d));
      chk("pready_drop", pready_v[d], 1'b0);
      chk("pslverr_drop", pslverr_v[d], 1'b0);
      @(negedge clk);
      chk("pulse_end", pulse_v[d], 4'h0);
    end
  endtask

  initial begin
    logic [31:0] rd, a;
    logic        er;
    int          lat, d, r;
    rom[0] = 4'b0000; rom[1] = 4'b1000;
    ws[0] = 0; ws[1] = 3;
    psel_v[0] = 1'b0; psel_v[1] = 1'b0; penable = 1'b0;
    paddr = 32'h0; pwrite = 1'b0; pwdata = 32'h0; pstrb = 4'h0;
    ro_data = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
    clear_model();

    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_pready", pready_v[i], 1'b0);
      chk("rst_pslverr", pslverr_v[i], 1'b0);
      chk("rst_prdata", prdata_v[i], 32'h0);
      chk("rst_regs", regs_v[i], 128'h0);
      chk("rst_pulse", pulse_v[i], 4'h0);
    end
    reset_n = 1'b1;

    for (int i = 0; i < 4; i++) run(0, 32'h10 + 32'(4*i), 1'b0, 32'h0, 4'h0, 1'b1);

    run(0, 32'h14, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1);
    chk("reg1_value", regs_v[0][63:32], 32'hDEAD_BEEF);
    run(0, 32'h14, 1'b0, 32'h0, 4'h0, 1'b1);

    run(0, 32'h10, 1'b1, 32'hAAAA_AAAA, 4'hF, 1'b1);
    run(0, 32'h10, 1'b1, 32'h1122_3344, 4'b0101, 1'b1);
    chk("reg0_merge", regs_v[0][31:0], 32'hAA22_AA44);
    run(0, 32'h10, 1'b0, 32'h0, 4'h0, 1'b1);

    run(0, 32'h20, 1'b0, 32'h0, 4'h0, 1'b1);
    run(0, 32'h0C, 1'b0, 32'h0, 4'h0, 1'b1);
    run(0, 32'h11, 1'b0, 32'h0, 4'h0, 1'b1);
    run(0, 32'h20, 1'b1, 32'h1111_1111, 4'hF, 1'b1);
    run(0, 32'h0C, 1'b1, 32'h2222_2222, 4'hF, 1'b1);
    run(0, 32'h11, 1'b1, 32'h3333_3333, 4'hF, 1'b1);
    run(0, 32'h18, 1'b1, 32'h4444_4444, 4'h0, 1'b1);

    run(0, 32'h18, 1'b1, 32'h0BAD_F00D, 4'hF, 1'b0);
    run(0, 32'h18, 1'b0, 32'h0, 4'h0, 1'b1);

    @(negedge clk);
    psel_v[0] = 1'b1; penable = 1'b1; paddr = 32'h10; pwrite = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("penable_no_setup", pready_v[0], 1'b0);
    end
    idle();

    run(1, 32'h1C, 1'b1, 32'h5A5A_5A5A, 4'hF, 1'b1);
    run(1, 32'h1C, 1'b0, 32'h0, 4'h0, 1'b1);
    run(1, 32'h14, 1'b1, 32'h0F0F_0F0F, 4'hF, 1'b1);
    run(1, 32'h14, 1'b0, 32'h0, 4'h0, 1'b1);

    @(negedge clk);
    psel_v[1] = 1'b1; penable = 1'b0; paddr = 32'h10; pwrite = 1'b1;
    pwdata = 32'h7777_7777; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel_v[1] = 1'b0; penable = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("abort_pready", pready_v[1], 1'b0);
      chk("abort_pulse", pulse_v[1], 4'h0);
    end
    chk("abort_regs", regs_v[1], m_regs(1));

    @(negedge clk);
    psel_v[1] = 1'b1; penable = 1'b0; paddr = 32'h18; pwrite = 1'b1;
    pwdata = 32'h1234_5678; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_wait_pready", pready_v[1], 1'b0);
    chk("rst_wait_regs1", regs_v[1], 128'h0);
    chk("rst_wait_regs0", regs_v[0], 128'h0);
    chk("rst_wait_pulse", pulse_v[1], 4'h0);
    clear_model();
    idle();
    reset_n = 1'b1;
    run(1, 32'h18, 1'b1, 32'h1234_5678, 4'hF, 1'b1);
    run(1, 32'h18, 1'b0, 32'h0, 4'h0, 1'b1);

    run(0, 32'h1C, 1'b1, 32'h9999_0000, 4'hF, 1'b1);
    xfer(0, 32'h1C, 1'b0, 32'h0, 4'h0, rd, er, lat);
    chk("resp_prdata", rd, 32'h9999_0000);
    chk("resp_pready", pready_v[0], 1'b1);
    reset_n = 1'b0;
    #1;
    chk("rst_resp_pready", pready_v[0], 1'b0);
    chk("rst_resp_prdata", prdata_v[0], 32'h0);
    chk("rst_resp_regs", regs_v[0], 128'h0);
    clear_model();
    idle();
    reset_n = 1'b1;
    run(0, 32'h1C, 1'b0, 32'h0, 4'h0, 1'b1);

    for (int k = 0; k < 80; k++) begin
      d = int'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      if (r < 7)       a = 32'h10 + 32'(4 * $urandom_range(0, 3));
      else if (r == 7) a = 32'h20 + 32'(4 * $urandom_range(0, 8));
      else if (r == 8) a = 32'h10 + 32'($urandom_range(0, 15) | 1);
      else             a = 32'(4 * $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) ro_data = {$urandom, $urandom, $urandom, $urandom};
      run(d, a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
          $urandom_range(0, 3) != 0);
    end
    idle();
    chk("final_regs0", regs_v[0], m_regs(0));
    chk("final_regs1", regs_v[1], m_regs(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
